// File: rtl/serial_neg_pkg.sv
// Shared types and helpers for the serial negation receiver.
// Optional error counter is enabled with SERIAL_NEG_ERRCNT_EN.
package serial_neg_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam int DEF_WIDTH = 4;

    // Word with only the MSB set: the self-negating value.
    function automatic logic [31:0] min_pattern(input int w);
        return 32'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/serial_neg_bit.sv
// Bit-serial negation cell: first-one / invert-rest rule.
// Shared with the serial inverter; seen1 clears at word start.
module serial_neg_bit (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    input  logic b_i,
    output logic r_o
);

    logic seen1_q;
    logic seen1_eff;

    assign seen1_eff = seen1_q & ~clr_i;
    assign r_o       = seen1_eff ? ~b_i : b_i;

    // Track whether a one has passed in the current word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seen1_q <= 1'b0;
        end else if (en_i) begin
            seen1_q <= seen1_eff | b_i;
        end
    end

endmodule

// File: rtl/serial_neg_rx.sv
// Serial negated-word receiver: frames LSB-first bits, recovers operand.
// Define SERIAL_NEG_ERRCNT_EN to add the saturating err_cnt output.
module serial_neg_rx
    import serial_neg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic             y_in,
    input  logic             bit_en,
    input  logic             frame,
    output logic [WIDTH-1:0] neg_out,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             is_min,
`ifdef SERIAL_NEG_ERRCNT_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             frame_err
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(min_pattern(WIDTH));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   neg_sh_q, neg_sh_d;
    logic [WIDTH-1:0]   dat_sh_q, dat_sh_d;
    logic [WIDTH:0]     neg_cat, dat_cat;
    logic [WIDTH-1:0]   neg_out_q, data_out_q;
    logic               out_valid_q, is_min_q, frame_err_q;
    logic               take, done, err, r_bit;

    serial_neg_bit u_bit (
        .clk_i  (t_clk),
        .rst_ni (r_n),
        .en_i   (take),
        .clr_i  (frame),
        .b_i    (y_in),
        .r_o    (r_bit)
    );

    // New bit enters at the MSB; after WIDTH bits bit 0 sits at the LSB.
    assign neg_cat  = {y_in, neg_sh_q};
    assign dat_cat  = {r_bit, dat_sh_q};
    assign neg_sh_d = neg_cat[WIDTH:1];
    assign dat_sh_d = dat_cat[WIDTH:1];

    // Next-state, bit count and completion/abort decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bit_en && frame) begin
                    take = 1'b1;
                    if (WIDTH == 1) begin
                        done  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    take = 1'b1;
                    if (frame) begin
                        err   = 1'b1;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // State, counter and shift registers.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            neg_sh_q <= '0;
            dat_sh_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                neg_sh_q <= neg_sh_d;
                dat_sh_q <= dat_sh_d;
            end
        end
    end

    // Output words hold between completions; strobes last one cycle.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            neg_out_q   <= '0;
            data_out_q  <= '0;
            is_min_q    <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            out_valid_q <= done;
            frame_err_q <= err;
            if (done) begin
                neg_out_q  <= neg_sh_d;
                data_out_q <= dat_sh_d;
                is_min_q   <= (neg_sh_d == MIN_W);
            end
        end
    end

`ifdef SERIAL_NEG_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of aborted words.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            err_cnt_q <= '0;
        end else if (err && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign neg_out   = neg_out_q;
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign is_min    = is_min_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_neg_rx.sv
// Self-checking bench for serial_neg_rx (WIDTH=4).
// Reference model collects accepted bits and negates arithmetically.
module tb_serial_neg_rx;

    localparam int W = 4;

    logic         t_clk = 1'b0;
    logic         r_n = 1'b0;
    logic         y_in = 1'b0;
    logic         bit_en = 1'b0;
    logic         frame = 1'b0;
    logic [W-1:0] neg_out;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         is_min;
    logic         frame_err;
`ifdef SERIAL_NEG_ERRCNT_EN
    logic [7:0]   err_cnt;
`endif

    int n_tests = 0;
    int n_fail = 0;

    // model state
    int           m_cnt = 0;
    int           m_acc = 0;
    logic         exp_valid = 0, exp_err = 0, exp_min = 0;
    logic [W-1:0] exp_neg = '0, exp_data = '0;
    int           exp_errcnt = 0;

    serial_neg_rx #(.WIDTH(W)) dut (
        .t_clk     (t_clk),
        .r_n       (r_n),
        .y_in      (y_in),
        .bit_en    (bit_en),
        .frame     (frame),
        .neg_out   (neg_out),
        .data_out  (data_out),
        .out_valid (out_valid),
        .is_min    (is_min),
`ifdef SERIAL_NEG_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .frame_err (frame_err)
    );

    always #5 t_clk = ~t_clk;

    task automatic model_clear();
        m_cnt = 0; m_acc = 0;
        exp_valid = 0; exp_err = 0; exp_min = 0;
        exp_neg = '0; exp_data = '0; exp_errcnt = 0;
    endtask

    // Drive one cycle, update the model at the edge, return #1 after it.
    task automatic step(input logic b, input logic en, input logic fr);
        int full;
        y_in = b; bit_en = en; frame = fr;
        @(posedge t_clk);
        exp_valid = 0; exp_err = 0;
        if (en) begin
            if (fr) begin
                if (m_cnt > 0) begin
                    exp_err = 1;
                    if (exp_errcnt < 255) exp_errcnt++;
                end
                m_cnt = 0; m_acc = 0;
            end
            if (fr || m_cnt > 0) begin
                m_acc += int'(b) << m_cnt;
                m_cnt++;
                if (m_cnt == W) begin
                    full = 1 << W;
                    exp_neg = m_acc[W-1:0];
                    exp_data = W'((full - m_acc) % full);
                    exp_min = (m_acc == (1 << (W - 1)));
                    exp_valid = 1;
                    m_cnt = 0; m_acc = 0;
                end
            end
        end
        #1;
        bit_en = 0; frame = 0;
    endtask

    task automatic send(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) step(w[i], 1'b1, i == 0);
    endtask

    task automatic test_reset();
        r_n = 0;
        repeat (2) @(posedge t_clk);
        #1;
        model_clear();
        n_tests++;
        if (neg_out !== '0 || data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_words: neg=%b data=%b expected 0", neg_out, data_out);
        end
        n_tests++;
        if (out_valid !== 0 || is_min !== 0 || frame_err !== 0) begin
            n_fail++;
            $display("FAIL reset_flags: v=%b min=%b err=%b expected 0", out_valid, is_min, frame_err);
        end
`ifdef SERIAL_NEG_ERRCNT_EN
        n_tests++;
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_errcnt: got %0d expected 0", err_cnt);
        end
`endif
        r_n = 1;
    endtask

    task automatic test_basic();
        logic [W-1:0] words[3] = '{4'b1101, 4'b0000, 4'b1000};
        logic [W-1:0] datas[3] = '{4'b0011, 4'b0000, 4'b1000};
        logic         mins[3]  = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            send(words[k]);
            n_tests++;
            if (out_valid !== 1 || neg_out !== words[k] || data_out !== datas[k] || is_min !== mins[k]) begin
                n_fail++;
                $display("FAIL basic_%0d: v=%b neg=%b data=%b min=%b expected 1 %b %b %b",
                         k, out_valid, neg_out, data_out, is_min, words[k], datas[k], mins[k]);
            end
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (out_valid !== 0 || neg_out !== words[k]) begin
                n_fail++;
                $display("FAIL basic_hold_%0d: v=%b neg=%b expected 0 %b", k, out_valid, neg_out, words[k]);
            end
        end
    endtask

    task automatic test_gap();
        logic [W-1:0] bits = 4'b1101;
        int early = 0;
        step(bits[0], 1'b1, 1'b1); early += int'(out_valid);
        step(bits[1], 1'b1, 1'b0); early += int'(out_valid);
        repeat (3) begin
            step(1'b1, 1'b0, 1'b1); early += int'(out_valid);
        end
        step(bits[2], 1'b1, 1'b0); early += int'(out_valid);
        n_tests++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL gap_early_valid: got %0d pulses expected 0", early);
        end
        step(bits[3], 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1 || neg_out !== 4'b1101 || data_out !== 4'b0011) begin
            n_fail++;
            $display("FAIL gap_word: v=%b neg=%b data=%b expected 1 1101 0011", out_valid, neg_out, data_out);
        end
    endtask

    task automatic test_frame_err();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (frame_err !== 1 || out_valid !== 0) begin
            n_fail++;
            $display("FAIL ferr_pulse: err=%b v=%b expected 1 0", frame_err, out_valid);
        end
        step(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (frame_err !== 0) begin
            n_fail++;
            $display("FAIL ferr_one_cycle: err=%b expected 0", frame_err);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1 || neg_out !== 4'b0010 || data_out !== 4'b1110 || frame_err !== 0) begin
            n_fail++;
            $display("FAIL ferr_restart: v=%b neg=%b data=%b err=%b expected 1 0010 1110 0",
                     out_valid, neg_out, data_out, frame_err);
        end
`ifdef SERIAL_NEG_ERRCNT_EN
        n_tests++;
        if (err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d expected 1", err_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        send(4'b0110);
        n_tests++;
        if (out_valid !== 1 || neg_out !== 4'b0110 || data_out !== 4'b1010) begin
            n_fail++;
            $display("FAIL b2b_first: v=%b neg=%b data=%b expected 1 0110 1010", out_valid, neg_out, data_out);
        end
        step(1'b1, 1'b1, 1'b1);
        n_tests++;
        if (out_valid !== 0 || frame_err !== 0) begin
            n_fail++;
            $display("FAIL b2b_start: v=%b err=%b expected 0 0", out_valid, frame_err);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1 || neg_out !== 4'b0111 || data_out !== 4'b1001) begin
            n_fail++;
            $display("FAIL b2b_second: v=%b neg=%b data=%b expected 1 0111 1001", out_valid, neg_out, data_out);
        end
    endtask

    task automatic test_reset_midword();
        int pulses = 0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        r_n = 0;
        #1;
        model_clear();
        n_tests++;
        if (neg_out !== '0 || data_out !== '0 || out_valid !== 0 || is_min !== 0 || frame_err !== 0) begin
            n_fail++;
            $display("FAIL midreset_outputs: neg=%b data=%b v=%b min=%b err=%b expected all 0",
                     neg_out, data_out, out_valid, is_min, frame_err);
        end
        @(posedge t_clk);
        #1;
        r_n = 1;
        for (int i = 0; i < W; i++) begin
            step(1'b1, 1'b1, i == 0);
            pulses += int'(out_valid);
        end
        n_tests++;
        if (neg_out !== 4'b1111 || data_out !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_word: neg=%b data=%b expected 1111 0001", neg_out, data_out);
        end
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0);
            pulses += int'(out_valid);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL midreset_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
            n_tests++;
            if (out_valid !== exp_valid || frame_err !== exp_err || neg_out !== exp_neg ||
                data_out !== exp_data || is_min !== exp_min) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_c%0d: v=%b err=%b neg=%b data=%b min=%b expected %b %b %b %b %b",
                             c, out_valid, frame_err, neg_out, data_out, is_min,
                             exp_valid, exp_err, exp_neg, exp_data, exp_min);
            end
`ifdef SERIAL_NEG_ERRCNT_EN
            n_tests++;
            if (err_cnt !== 8'(exp_errcnt)) begin
                n_fail++;
                $display("FAIL random_errcnt_c%0d: got %0d expected %0d", c, err_cnt, exp_errcnt);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_frame_err();
        test_back_to_back();
        test_reset_midword();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_neg_rx.md
Name: serial_neg_rx

Overview:
- Receiving end of the serial two's-complement link: accepts the LSB-first negated bit stream produced by the serial inverter.
- Frames it into WIDTH-bit words and undoes the negation bit-serially (first-one/invert-rest rule) to recover the original operand.
- Presents both the received negated word and the recovered word in parallel with a one-cycle valid strobe.
- Sits between the serial inverter output and the parallel datapath/checker.

Parameters:
- WIDTH, 4, word length in bits (>=1).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter.

Ports:
- t_clk  in  1  system clock; all state changes on its rising edge.
- r_n  in  1  reset, asynchronous and active-low.
- y_in  in  1  serial negated data bit, LSB first.
- bit_en  in  1  y_in is valid this cycle.
- frame  in  1  qualified with bit_en: this bit is bit 0 of a new word.
- neg_out  out  WIDTH  received word, as it came off the link.
- data_out  out  WIDTH  recovered original word, equal to -neg_out mod 2^WIDTH.
- out_valid  out  1  one-cycle pulse: neg_out/data_out just updated.
- is_min  out  1  neg_out = 1 followed by WIDTH-1 zeros (self-negating value); valid with out_valid.
- frame_err  out  1  one-cycle pulse: word aborted by an early frame.

Behaviour:
- Reset (r_n=0, async): state=IDLE, cnt=0, seen1=0, shift registers=0, neg_out=0, data_out=0, out_valid=0, is_min=0, frame_err=0.
- Accepted bit = rising edge with bit_en=1. Cycles with bit_en=0 hold all state; gaps of any length are allowed mid-word.
- Per-bit recovery on each accepted bit b:
  - seen1 is taken as 0 if frame=1.
  - recovered bit r = seen1 ? ~b : b.
  - seen1_next = seen1 | b.
- Both shift registers shift right; the new bit enters at the MSB, so after WIDTH bits bit 0 is at the LSB.
- FSM:
  - IDLE: accepted bit with frame=1 -> load bit 0, cnt=1, go to SHIFT. If WIDTH=1, complete immediately and stay in IDLE. Accepted bits without frame are ignored. frame without bit_en is ignored.
  - SHIFT, accepted bit with frame=0: cnt++.
  - SHIFT, cnt reaches WIDTH: completion. Next cycle out_valid=1, neg_out/data_out/is_min register the final values, return to IDLE, cnt=0.
  - SHIFT, accepted bit with frame=1 before completion: frame_err=1 next cycle. The partial word is discarded with no out_valid. This bit restarts as bit 0 (cnt=1, seen1 from this bit).
- Back-to-back words: a frame bit accepted the cycle after the last bit is legal. out_valid for the old word and the start of the new word coexist.
- Outputs hold between updates. out_valid and frame_err are never both 1 for the same word.
- Latency: last bit accepted at edge k -> out_valid high during cycle k+1.
- Reset mid-word: the partial word is lost and no out_valid is produced.

Optional Feature:
- Macro: SERIAL_NEG_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt [7:0].
  - Increments on every frame_err and saturates at 255.
  - Cleared only by r_n.
- Undefined: the port and counter do not exist; frame_err behaviour is unchanged.

Decomposition:
- Package serial_neg_pkg:
  - state enum {IDLE, SHIFT};
  - default WIDTH constant;
  - function min_pattern(WIDTH) returning 1 followed by zeros.
- Sub-module serial_neg_bit:
  - holds the seen1 flag with a synchronous clear on frame;
  - produces r from b;
  - is the same cell the serial inverter uses, instantiated once here.

Test Plan (WIDTH=4):
- Reset then frame/bit_en with y_in=1,0,1,1 on consecutive cycles -> one cycle after the 4th bit: out_valid=1, neg_out=1101, data_out=0011, is_min=0.
- Stream 0,0,0,0 -> neg_out=0000, data_out=0000, is_min=0.
- Stream 0,0,0,1 -> neg_out=1000, data_out=1000, is_min=1.
- Stream 1,0,1,1 with bit_en low for 3 cycles between bits 2 and 3 -> same result as scenario 1; out_valid appears one cycle after the final accepted bit only.
- Frame at bit 0, bits 1,1, then frame again with 0,1,0,0 -> frame_err pulse after the 3rd accepted bit. Next: neg_out=0010, data_out=1110. With SERIAL_NEG_ERRCNT_EN, err_cnt=1.
- r_n pulsed low after 2 bits, then a full word 1,1,1,1 -> all outputs 0 during reset. Then neg_out=1111, data_out=0001, with exactly one out_valid.
